// File: rtl/register_file_pkg.sv
// Shared architectural constants for the register file, ALU, decoder and core top.
package register_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WCOUNT_W   = 16;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // x0 is hardwired to zero, so it is never a legal write target.
    function automatic logic is_writable(input logic [REG_ADDR_W-1:0] addr);
        return addr != ZERO_REG;
    endfunction

endpackage

// File: rtl/register_file.sv
// Two-read / one-write integer register file with optional write-to-read forwarding
// and a count of committed writes.
module register_file
    import register_file_pkg::REG_ADDR_W, register_file_pkg::NUM_REGS,
           register_file_pkg::WCOUNT_W, register_file_pkg::ZERO_REG,
           register_file_pkg::is_writable;
#(
    parameter int BYPASS = 1,
    parameter int XLEN   = register_file_pkg::XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] A1,
    input  logic [REG_ADDR_W-1:0] A2,
    input  logic [REG_ADDR_W-1:0] A3,
    input  logic [XLEN-1:0]       WD3,
    input  logic                  WE3,
    output logic [XLEN-1:0]       RD1,
    output logic [XLEN-1:0]       RD2,
    output logic [WCOUNT_W-1:0]   WriteCount
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [WCOUNT_W-1:0] write_count_q;
    logic [WCOUNT_W-1:0] write_count_d;
    logic                wr_fire;
    logic                fwd_en;

    // Gating with rst keeps a write presented during reset from forwarding as well.
    always_comb begin
        wr_fire = 1'b0;
        if (WE3 === 1'b1 && rst) begin
            wr_fire = is_writable(A3);
        end
        fwd_en = (BYPASS != 0) && wr_fire;
    end

    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (wr_fire) begin
            regs_d[A3]    = WD3;
            write_count_d = write_count_q + 1'b1;
        end
        regs_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    always_comb begin
        RD1 = regs_q[A1];
        if (A1 == ZERO_REG) begin
            RD1 = '0;
        end else if (fwd_en && A1 == A3) begin
            RD1 = WD3;
        end

        RD2 = regs_q[A2];
        if (A2 == ZERO_REG) begin
            RD2 = '0;
        end else if (fwd_en && A2 == A3) begin
            RD2 = WD3;
        end
    end

    assign WriteCount = write_count_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench: one forwarding instance and one non-forwarding instance share stimulus.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd3;
    logic        we3;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic [15:0] wc_b, wc_n;

    int n_cmp;
    int n_bad;

    register_file #(.BYPASS(1), .XLEN(32)) u_byp (
        .clk(clk), .rst(rst_n), .A1(a1), .A2(a2), .A3(a3),
        .WD3(wd3), .WE3(we3), .RD1(rd1_b), .RD2(rd2_b), .WriteCount(wc_b)
    );

    register_file #(.BYPASS(0), .XLEN(32)) u_nob (
        .clk(clk), .rst(rst_n), .A1(a1), .A2(a2), .A3(a3),
        .WD3(wd3), .WE3(we3), .RD1(rd1_n), .RD2(rd2_n), .WriteCount(wc_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        we3 = 1'b1;
        a3  = addr;
        wd3 = data;
        tick();
        we3 = 1'b0;
    endtask

    logic [2:0]  alu_ctl;
    logic [31:0] alu_res;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        a1 = 5'd0; a2 = 5'd0; a3 = 5'd0; wd3 = 32'h0; we3 = 1'b0;
        alu_ctl = 3'b000; alu_res = 32'h0;

        // Reset state
        #3;
        a1 = 5'd7;
        #1;
        chk("reset_rd1_b", rd1_b, 32'h0);
        chk("reset_rd1_n", rd1_n, 32'h0);
        chk("reset_wc_b", {16'h0, wc_b}, 32'h0);
        tick();
        rst_n = 1'b1;

        // Plain write then read on both ports
        wr(5'd7, 32'h0000_1234);
        a1 = 5'd7; a2 = 5'd7;
        #1;
        chk("wr_rd1_b", rd1_b, 32'h0000_1234);
        chk("wr_rd2_b", rd2_b, 32'h0000_1234);
        chk("wr_rd1_n", rd1_n, 32'h0000_1234);
        chk("wr_wc_b", {16'h0, wc_b}, 32'd1);

        // x0 write, including the forwarding cycle
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFF_FFFF; a1 = 5'd0; a2 = 5'd0;
        #1;
        chk("x0_pre_rd1_b", rd1_b, 32'h0);
        chk("x0_pre_rd2_b", rd2_b, 32'h0);
        tick();
        we3 = 1'b0;
        #1;
        chk("x0_post_rd1_b", rd1_b, 32'h0);
        chk("x0_post_rd1_n", rd1_n, 32'h0);
        chk("x0_wc_b", {16'h0, wc_b}, 32'd1);

        // Forwarding versus registered read
        wr(5'd3, 32'd1);
        we3 = 1'b1; a3 = 5'd3; wd3 = 32'd9; a1 = 5'd3; a2 = 5'd3;
        #1;
        chk("byp_pre_rd1_b", rd1_b, 32'd9);
        chk("byp_pre_rd2_b", rd2_b, 32'd9);
        chk("byp_pre_rd1_n", rd1_n, 32'd1);
        chk("byp_pre_rd2_n", rd2_n, 32'd1);
        tick();
        we3 = 1'b0;
        #1;
        chk("byp_post_rd1_n", rd1_n, 32'd9);
        chk("byp_post_rd1_b", rd1_b, 32'd9);
        chk("byp_wc_n", {16'h0, wc_n}, 32'd3);

        // Asynchronous reset between edges
        wr(5'd5, 32'hDEAD_BEEF);
        a1 = 5'd5;
        #1;
        chk("x5_before_rst", rd1_b, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        chk("rst_async_rd1_b", rd1_b, 32'h0);
        chk("rst_async_rd1_n", rd1_n, 32'h0);
        chk("rst_async_wc_b", {16'h0, wc_b}, 32'h0);

        // Write presented during reset is dropped and does not forward
        we3 = 1'b1; a3 = 5'd6; wd3 = 32'h0000_00AA; a2 = 5'd6;
        #1;
        chk("rst_nofwd_rd2_b", rd2_b, 32'h0);
        tick();
        chk("rst_drop_rd2_b", rd2_b, 32'h0);
        chk("rst_drop_wc_b", {16'h0, wc_b}, 32'h0);
        we3 = 1'b0;
        rst_n = 1'b1;
        a1 = 5'd7;
        #1;
        chk("rst_clear_x7", rd1_n, 32'h0);

        // First edge after release accepts a write
        wr(5'd6, 32'h0000_00AA);
        chk("first_wr_rd2_n", rd2_n, 32'h0000_00AA);
        chk("first_wr_wc_n", {16'h0, wc_n}, 32'd1);

        // Idle cycle with garbage address/data changes nothing
        we3 = 1'b0; a3 = 5'd6; wd3 = 32'h5555_5555;
        tick();
        chk("idle_rd2_n", rd2_n, 32'h0000_00AA);
        chk("idle_wc_n", {16'h0, wc_n}, 32'd1);

        // ALU loop through the register file
        wr(5'd1, 32'd5);
        wr(5'd2, 32'd3);
        a1 = 5'd1; a2 = 5'd2;
        for (int k = 0; k < 2; k++) begin
            alu_ctl = (k == 0) ? 3'b001 : 3'b011;
            #1;
            case (alu_ctl)
                3'b000:  alu_res = rd1_n + rd2_n;
                3'b001:  alu_res = rd1_n - rd2_n;
                3'b010:  alu_res = rd1_n & rd2_n;
                3'b011:  alu_res = rd1_n | rd2_n;
                default: alu_res = 32'h0;
            endcase
            wr(5'd4, alu_res);
            a1 = 5'd4;
            #1;
            chk((k == 0) ? "alu_sub_x4" : "alu_or_x4", rd1_n, (k == 0) ? 32'd2 : 32'd7);
            a1 = 5'd1;
        end
        chk("alu_wc_b", {16'h0, wc_b}, 32'd5);

        // Counter wrap: fresh reset, 65535 writes to x1, then one more
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        a1 = 5'd1;
        we3 = 1'b1; a3 = 5'd1;
        for (int i = 1; i <= 65535; i++) begin
            wd3 = i;
            tick();
        end
        we3 = 1'b0;
        #1;
        chk("wrap_pre_wc_b", {16'h0, wc_b}, 32'h0000_FFFF);
        chk("wrap_pre_x1", rd1_n, 32'h0000_FFFF);
        wr(5'd1, 32'hCAFE_F00D);
        chk("wrap_wc_b", {16'h0, wc_b}, 32'h0);
        chk("wrap_wc_n", {16'h0, wc_n}, 32'h0);
        chk("wrap_x1_b", rd1_b, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The module SHALL take parameter BYPASS, default 1, which enables same-cycle write-to-read forwarding on both read ports.
REQ-002 The module SHALL take parameter XLEN, default 32, which sets the data width of every register and data port.
REQ-003 clk  input  1  single clock; all register state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; rst=0 SHALL clear all state immediately, independent of clk.
REQ-005 A1  input  5  read-port-1 register index; RD1 feeds ALU operand A.
REQ-006 A2  input  5  read-port-2 register index; RD2 feeds ALU operand B or the store data.
REQ-007 A3  input  5  write-port register index.
REQ-008 WD3  input  XLEN  write data; sources are ALU Result, load data or PC+4.
REQ-009 WE3  input  1  write enable; active-high.
REQ-010 RD1  output  XLEN  read data for A1.
REQ-011 RD2  output  XLEN  read data for A2.
REQ-012 WriteCount  output  16  count of committed writes, excluding writes to x0.

Function
REQ-013 Storage SHALL be 32 registers of XLEN bits, x0..x31.
REQ-014 x0 SHALL always read 0; writes to A3=0 SHALL be discarded and SHALL NOT increment WriteCount.
REQ-015 A write SHALL commit at the rising clk edge when WE3=1, rst=1 and A3!=0: reg[A3] <= WD3.
REQ-016 Reads SHALL be combinational, with zero-cycle latency from A1/A2 to RD1/RD2.
REQ-017 With BYPASS=1, when WE3=1, A3!=0 and A1==A3, RD1 SHALL equal WD3 in the same cycle; the same rule SHALL apply to A2/RD2.
REQ-018 With BYPASS=0, reads SHALL return the pre-edge stored value; the new value SHALL be visible on the cycle after the commit.
REQ-019 Both ports SHALL allow A1==A2 at the same time, including both forwarding from one write.
REQ-020 WriteCount SHALL increment by 1 per committed write and SHALL wrap from 16'hFFFF to 0 without a flag.
REQ-021 WE3=0 SHALL leave all state and WriteCount unchanged, whatever the values of A3 and WD3.
REQ-022 Bypass SHALL be suppressed for A3=0, so RD1/RD2 SHALL stay 0 for index 0 even when WE3=1.
REQ-023 X/unknown on A3 or WD3 with WE3=0 SHALL have no effect on state.

Reset
REQ-024 When rst=0, all registers x1..x31 and WriteCount SHALL be 0 asynchronously, and RD1/RD2 SHALL read 0 for any index.
REQ-025 A write coinciding with rst=0 SHALL be dropped; reset SHALL win.
REQ-026 Deassertion SHALL be synchronised externally; the first write SHALL be accepted at the first rising edge with rst=1.
REQ-027 Reset mid-program SHALL discard all architectural state; no partial retention is permitted.

Structure
REQ-028 The shared package SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and ZERO_REG=5'd0; the ALU, decoder and core top SHALL import the same constants.
REQ-029 The module SHALL be a single module with no sub-module; the storage array, forwarding muxes and counter SHALL be local.
REQ-030 The storage SHALL be a flip-flop array, not inferred RAM, so that it clears asynchronously.

Verification
REQ-031 Reset: write x5=32'hDEADBEEF, pulse rst=0 between edges -> RD1(A1=5)=0 at once; WriteCount=0.
REQ-032 Write/read: WE3=1, A3=7, WD3=32'h0000_1234, edge; then A1=7, A2=7 -> RD1=RD2=32'h0000_1234; WriteCount=1.
REQ-033 x0: WE3=1, A3=0, WD3=32'hFFFF_FFFF, edge -> RD1(A1=0)=0, including the pre-edge bypass cycle; WriteCount unchanged.
REQ-034 Bypass: BYPASS=1, x3=1, then WE3=1, A3=3, WD3=9, A1=3 in the same cycle -> RD1=9 pre-edge; with BYPASS=0 -> RD1=1 pre-edge and 9 post-edge.
REQ-035 Counter wrap: preload WriteCount to 16'hFFFF via 65535 writes to x1 -> the next write gives WriteCount=0 and x1 holds the last WD3.
REQ-036 ALU loop: x1=5, x2=3, RD1/RD2 drive the ALU with ALUControl=001, Result written to x4 -> x4 reads 2; with ALUControl=011 -> x4 reads 7.
